// File: rtl/addr8_io_stage.sv
// Registered operand/result wrapper around an external 8-bit combinational adder.
// Operands enter over valid/ready, the sum lands in a small result FIFO, and saturating counters track pushes and carries.
module addr8_io_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic [15:0]      add_x,
    input  logic [8:0]       add_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8:0]       out_sum,
    output logic [CNT_W-1:0] op_cnt,
    output logic [CNT_W-1:0] carry_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic             op_valid_q, op_valid_d;
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;
    logic [8:0]       mem_q [DEPTH];
    logic [8:0]       mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
    logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;
    logic             push, pop, accept;

    assign out_valid = (count_q != '0);
    assign out_sum   = mem_q[rd_ptr_q];
    assign add_x     = {b_q, a_q};
    assign op_cnt    = op_cnt_q;
    assign carry_cnt = carry_cnt_q;

    assign pop      = out_valid & out_ready;
    assign push     = op_valid_q & ((count_q < FULL) | pop);
    assign in_ready = ~op_valid_q | push;
    assign accept   = in_valid & in_ready;

    always_comb begin
        op_valid_d  = op_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        op_cnt_d    = op_cnt_q;
        carry_cnt_d = carry_cnt_q;

        // S1: operand register feeding the adder
        if (accept) begin
            op_valid_d = 1'b1;
            a_d        = in_a;
            b_d        = in_b;
        end else if (push) begin
            op_valid_d = 1'b0;
        end

        // S2: result FIFO, pointers wrap naturally at a power-of-two depth
        if (push) begin
            mem_d[wr_ptr_q] = add_y;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        if (clr) begin
            op_cnt_d    = '0;
            carry_cnt_d = '0;
        end else if (push) begin
            op_cnt_d = sat_inc(op_cnt_q);
            if (add_y[8]) begin
                carry_cnt_d = sat_inc(carry_cnt_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            op_cnt_q    <= '0;
            carry_cnt_q <= '0;
        end else begin
            op_valid_q  <= op_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            op_cnt_q    <= op_cnt_d;
            carry_cnt_q <= carry_cnt_d;
        end
    end

endmodule

// File: tb/tb_addr8_io_stage.sv
// Scoreboard bench for addr8_io_stage: the driver queues hand-computed sums on acceptance,
// a negedge monitor pops and compares whenever a result is handed off.
module tb_addr8_io_stage;

    localparam int DEPTH = 2;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_a = '0;
    logic [7:0]       in_b = '0;
    logic [15:0]      add_x;
    logic [8:0]       add_y;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [8:0]       out_sum;
    logic [CNT_W-1:0] op_cnt;
    logic [CNT_W-1:0] carry_cnt;

    int n_vec  = 0;
    int n_fail = 0;
    logic [8:0] exp_q[$];

    addr8_io_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .add_x(add_x), .add_y(add_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .op_cnt(op_cnt), .carry_cnt(carry_cnt)
    );

    // external combinational ripple-carry adder
    assign add_y = {1'b0, add_x[7:0]} + {1'b0, add_x[15:8]};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {23'd0, out_sum}, 32'h0000_0dead);
            end else begin
                check("out_sum", {23'd0, out_sum}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    // Drive one operand pair; returns #1 after the accepting edge with in_valid low.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] sum,
                        output int waited);
        bit done = 0;
        waited = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(sum);
                done = 1;
            end else begin
                waited++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !out_valid) done = 1;
        end
        check("drain", {31'd0, done}, 32'd1);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        clr = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    int w;

    initial begin
        do_reset();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_add_x", {16'd0, add_x}, 32'd0);
        check("rst_out_sum", {23'd0, out_sum}, 32'd0);
        check("rst_op_cnt", {30'd0, op_cnt}, 32'd0);
        check("rst_carry_cnt", {30'd0, carry_cnt}, 32'd0);

        // 1: single zero operand, two-edge latency
        out_ready = 1'b1;
        send(8'h00, 8'h00, 9'h000, w);
        check("t1_not_yet_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("t1_valid_after_2", {31'd0, out_valid}, 32'd1);
        wait_drain();
        check("t1_op_cnt", {30'd0, op_cnt}, 32'd1);
        check("t1_carry_cnt", {30'd0, carry_cnt}, 32'd0);

        // 2: back-to-back carries
        do_reset();
        out_ready = 1'b1;
        send(8'hFF, 8'h01, 9'h100, w);
        send(8'hFF, 8'hFF, 9'h1FE, w);
        check("t2_b2b_no_wait", w, 32'd0);
        @(posedge clk);
        #1;
        check("t2_second_on_next", {23'd0, out_sum}, 32'h1FE);
        wait_drain();
        check("t2_carry_cnt", {30'd0, carry_cnt}, 32'd2);

        // 3: backpressure with FIFO full and S1 holding
        do_reset();
        out_ready = 1'b0;
        send(8'd1, 8'd1, 9'd2, w);
        send(8'd2, 8'd2, 9'd4, w);
        send(8'd3, 8'd3, 9'd6, w);
        fork
            send(8'd4, 8'd4, 9'd8, w);
            begin
                @(negedge clk);
                check("t3_in_ready_low", {31'd0, in_ready}, 32'd0);
                check("t3_s1_holds", {16'd0, add_x}, 32'h0303);
                check("t3_out_head", {23'd0, out_sum}, 32'd2);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        check("t3_fourth_waited", {31'd0, w != 0}, 32'd1);
        wait_drain();

        // 4: full FIFO plus S1, push and pop in the same cycle
        do_reset();
        out_ready = 1'b0;
        send(8'd10, 8'd20, 9'd30, w);
        send(8'd30, 8'd40, 9'd70, w);
        send(8'd50, 8'd60, 9'd110, w);
        out_ready = 1'b1;
        send(8'd70, 8'd80, 9'd150, w);
        check("t4_stream0", w, 32'd0);
        send(8'd90, 8'd100, 9'd190, w);
        check("t4_stream1", w, 32'd0);
        send(8'd200, 8'd55, 9'd255, w);
        check("t4_stream2", w, 32'd0);
        wait_drain();

        // 5: asynchronous reset with results pending
        do_reset();
        out_ready = 1'b0;
        send(8'd5, 8'd6, 9'd11, w);
        send(8'd7, 8'd8, 9'd15, w);
        send(8'd9, 8'd9, 9'd18, w);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t5_out_valid", {31'd0, out_valid}, 32'd0);
        check("t5_add_x", {16'd0, add_x}, 32'd0);
        check("t5_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("t5_no_stale", {31'd0, out_valid}, 32'd0);

        // 6: saturating counters and clear priority
        do_reset();
        out_ready = 1'b1;
        send(8'd128, 8'd128, 9'd256, w);
        send(8'd255, 8'd1, 9'd256, w);
        send(8'd200, 8'd100, 9'd300, w);
        send(8'd129, 8'd127, 9'd256, w);
        send(8'd255, 8'd255, 9'd510, w);
        wait_drain();
        check("t6_op_sat", {30'd0, op_cnt}, 32'd3);
        check("t6_carry_sat", {30'd0, carry_cnt}, 32'd3);
        clr = 1'b1;
        send(8'd255, 8'd255, 9'd510, w);
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("t6_op_clr", {30'd0, op_cnt}, 32'd0);
        check("t6_carry_clr", {30'd0, carry_cnt}, 32'd0);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
